// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for the two-port SRAM arbiter: port 0 (CPU/io_manager)
// and port 1 (sample logger).
interface sram_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [17:0] addr0;
    logic [17:0] addr1;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic [1:0]  be0;
    logic [1:0]  be1;
    logic        ack0;
    logic        ack1;
    logic [15:0] rdata0;
    logic [15:0] rdata1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1,
        input  ack0, ack1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1,
        output ack0, ack1, rdata0, rdata1
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and fixed-length cycle sequencer for the external async SRAM;
// owns the tri-state data bus.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    sram_arbiter_if.slave      bus,
    output logic [17:0]        direcciones,
    output logic [4:0]         sram_control,
    inout  wire  [15:0]        datos
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;

    logic        last_cycle;
    logic        drive_en;
    logic [15:0] rd_base;
    logic [15:0] rd_merge;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        last_cycle = (cnt_q == 4'(WAIT_CYCLES - 1));
        // Disabled byte lanes keep the previous read value of the granted port.
        rd_base  = gnt_q ? rdata1_q : rdata0_q;
        rd_merge = {be_q[1] ? datos[15:8] : rd_base[15:8],
                    be_q[0] ? datos[7:0]  : rd_base[7:0]};

        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    if (bus.req0 && bus.req1) begin
                        gnt_d        = ~last_grant_q;
                        last_grant_d = ~last_grant_q;
                    end else begin
                        gnt_d = bus.req1;
                    end
                    we_d    = gnt_d ? bus.we1    : bus.we0;
                    addr_d  = gnt_d ? bus.addr1  : bus.addr0;
                    wdata_d = gnt_d ? bus.wdata1 : bus.wdata0;
                    be_d    = gnt_d ? bus.be1    : bus.be0;
                    cnt_d   = 4'd0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 4'd1;
                if (last_cycle) begin
                    state_d = StDone;
                    // Captured on the last strobe cycle so rdata is valid alongside ack.
                    if (!we_q) begin
                        if (gnt_q) rdata1_d = rd_merge;
                        else       rdata0_d = rd_merge;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 18'd0;
            wdata_q      <= 16'd0;
            be_q         <= 2'b00;
            rdata0_q     <= 16'd0;
            rdata1_q     <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        sram_control = 5'b11111;
        if (state_q == StAccess) begin
            sram_control = {1'b0, we_q, ~we_q, ~be_q[1], ~be_q[0]};
        end
        bus.ack0   = (state_q == StDone) && !gnt_q;
        bus.ack1   = (state_q == StDone) && gnt_q;
        bus.rdata0 = rdata0_q;
        bus.rdata1 = rdata1_q;
        direcciones = addr_q;
        // Writes hold the bus through DONE for hold time and turnaround.
        drive_en = we_q && (state_q != StIdle);
    end

    assign datos = drive_en ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: W=2 main instance with an SRAM model, plus W=1 and
// W=5 instances for latency.
module tb_sram_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_arbiter_if bus ();
    sram_arbiter_if bus_w1 ();
    sram_arbiter_if bus_w5 ();

    wire  [15:0] datos;
    wire  [15:0] datos_w1;
    wire  [15:0] datos_w5;
    logic [17:0] dir, dir_w1, dir_w5;
    logic [4:0]  ctrl, ctrl_w1, ctrl_w5;

    // Undriven bus reads as FFFF, which stands in for high-Z in the checks.
    pullup pu_d (datos);
    pullup pu_d1 (datos_w1);
    pullup pu_d5 (datos_w5);

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .direcciones(dir), .sram_control(ctrl), .datos(datos)
    );
    sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset(reset), .bus(bus_w1.slave),
        .direcciones(dir_w1), .sram_control(ctrl_w1), .datos(datos_w1)
    );
    sram_arbiter #(.WAIT_CYCLES(5)) dut_w5 (
        .clk(clk), .reset(reset), .bus(bus_w5.slave),
        .direcciones(dir_w5), .sram_control(ctrl_w5), .datos(datos_w5)
    );

    // SRAM model, ctrl = {ce_n, oe_n, we_n, ub_n, lb_n}
    logic [15:0] mem [0:255];
    assign datos = (!ctrl[4] && !ctrl[3]) ? mem[dir[7:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!ctrl[4] && !ctrl[2]) begin
            if (!ctrl[1]) mem[dir[7:0]][15:8] <= datos[15:8];
            if (!ctrl[0]) mem[dir[7:0]][7:0]  <= datos[7:0];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus.be0 = 0; bus.be1 = 0;
        bus_w1.req0 = 0; bus_w1.req1 = 0; bus_w1.we0 = 0; bus_w1.we1 = 0;
        bus_w1.addr0 = 0; bus_w1.addr1 = 0; bus_w1.wdata0 = 0; bus_w1.wdata1 = 0;
        bus_w1.be0 = 0; bus_w1.be1 = 0;
        bus_w5.req0 = 0; bus_w5.req1 = 0; bus_w5.we0 = 0; bus_w5.we1 = 0;
        bus_w5.addr0 = 0; bus_w5.addr1 = 0; bus_w5.wdata0 = 0; bus_w5.wdata1 = 0;
        bus_w5.be0 = 0; bus_w5.be1 = 0;
    endtask

    initial begin
        int acks;
        int last_cyc;
        int ack0_cyc;
        int ack1_cyc;
        int n_ack0;
        int w1_cyc;
        int w5_cyc;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        idle_bus();

        // Reset and idle
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_ctrl", ctrl, 5'b11111);
        check("rst_datos_z", datos, 16'hFFFF);
        check("rst_ack0", bus.ack0, 1'b0);
        check("rst_ack1", bus.ack1, 1'b0);
        check("rst_rdata0", bus.rdata0, 16'h0000);
        check("rst_rdata1", bus.rdata1, 16'h0000);
        check("rst_dir", dir, 18'h0);
        check("rst_dir_w1", dir_w1, 18'h0);
        check("rst_dir_w5", dir_w5, 18'h0);

        // Port 0 write
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 18'h00010; bus.wdata0 = 16'hABCD; bus.be0 = 2'b11;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check("wr_ctrl", ctrl, 5'b01000);
            check("wr_datos", datos, 16'hABCD);
            check("wr_dir", dir, 18'h00010);
            check("wr_ack0_early", bus.ack0, 1'b0);
        end
        @(negedge clk);
        check("wr_ack0", bus.ack0, 1'b1);
        check("wr_ack1", bus.ack1, 1'b0);
        check("wr_done_ctrl", ctrl, 5'b11111);
        check("wr_done_datos", datos, 16'hABCD);
        check("wr_done_dir", dir, 18'h00010);
        bus.req0 = 0;
        @(negedge clk);
        check("wr_idle_datos_z", datos, 16'hFFFF);
        check("wr_idle_ack0", bus.ack0, 1'b0);
        check("wr_mem", mem[8'h10], 16'hABCD);

        // Port 1 read, lower byte only
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 18'h00010; bus.be1 = 2'b01;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            check("rd_ctrl", ctrl, 5'b00110);
            check("rd_ack1_early", bus.ack1, 1'b0);
        end
        @(negedge clk);
        check("rd_ack1", bus.ack1, 1'b1);
        check("rd_ack0", bus.ack0, 1'b0);
        check("rd_rdata1", bus.rdata1, 16'h00CD);
        check("rd_rdata0", bus.rdata0, 16'h0000);
        check("rd_done_ctrl", ctrl, 5'b11111);
        bus.req1 = 0;
        @(negedge clk);

        // Both ports requesting continuously
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 18'h00010; bus.be0 = 2'b11;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 18'h00010; bus.be1 = 2'b10;
        acks = 0;
        last_cyc = 0;
        for (int cyc = 1; cyc <= 40 && acks < 4; cyc++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                check("tie_single_ack", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
                check("tie_order", {31'd0, bus.ack1}, (acks % 2 == 0) ? 32'd0 : 32'd1);
                if (acks == 0) check("tie_first_cyc", cyc, 32'd3);
                else           check("tie_spacing", cyc - last_cyc, 32'd4);
                last_cyc = cyc;
                acks++;
                if (acks == 4) begin
                    bus.req0 = 0; bus.req1 = 0;
                end
            end
        end
        check("tie_count", acks, 32'd4);
        @(negedge clk);
        check("tie_rdata0", bus.rdata0, 16'hABCD);
        check("tie_rdata1", bus.rdata1, 16'hABCD);

        // Reset in the 2nd ACCESS cycle of a write
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 18'h00020; bus.wdata0 = 16'h1234; bus.be0 = 2'b11;
        @(negedge clk);
        check("ab_ctrl", ctrl, 5'b01000);
        @(negedge clk);
        reset = 1'b1;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 18'h00010; bus.be1 = 2'b00;
        @(negedge clk);
        check("ab_ctrl_idle", ctrl, 5'b11111);
        check("ab_datos_z", datos, 16'hFFFF);
        check("ab_ack0", bus.ack0, 1'b0);
        check("ab_ack1", bus.ack1, 1'b0);
        check("ab_rdata0", bus.rdata0, 16'h0000);
        check("ab_rdata1", bus.rdata1, 16'h0000);
        reset = 1'b0;
        ack0_cyc = 0;
        ack1_cyc = 0;
        n_ack0 = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 5) check("be00_ctrl", ctrl, 5'b00111);
            if (bus.ack0) begin
                n_ack0++;
                if (ack0_cyc == 0) ack0_cyc = cyc;
                bus.req0 = 0;
            end
            if (bus.ack1) begin
                if (ack1_cyc == 0) ack1_cyc = cyc;
                bus.req1 = 0;
            end
        end
        check("ab_port0_first", ack0_cyc, 32'd3);
        check("ab_port1_next", ack1_cyc, 32'd7);
        check("ab_ack0_count", n_ack0, 32'd1);
        check("be00_rdata1", bus.rdata1, 16'h0000);

        // Latency of W=1 and W=5 builds
        bus_w1.req0 = 1; bus_w1.we0 = 0; bus_w1.addr0 = 18'h5; bus_w1.be0 = 2'b11;
        bus_w5.req0 = 1; bus_w5.we0 = 0; bus_w5.addr0 = 18'h5; bus_w5.be0 = 2'b11;
        w1_cyc = 0;
        w5_cyc = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (bus_w1.ack0 && w1_cyc == 0) begin
                w1_cyc = cyc;
                bus_w1.req0 = 0;
            end
            if (bus_w5.ack0 && w5_cyc == 0) begin
                w5_cyc = cyc;
                bus_w5.req0 = 0;
            end
        end
        check("w1_ack_cyc", w1_cyc, 32'd2);
        check("w5_ack_cyc", w5_cyc, 32'd6);
        check("w1_rdata0", bus_w1.rdata0, 16'hFFFF);
        check("w5_rdata0", bus_w5.rdata0, 16'hFFFF);
        check("w1_ctrl_idle", ctrl_w1, 5'b11111);
        check("w5_ctrl_idle", ctrl_w5, 5'b11111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
